// File: rtl/rv64_alu_pkg.sv
// Shared ALU opcodes and requester ids for the arbitrated 64-bit ALU.
// No logic: constants and one helper only.
// Not applicable (no handshake in this file).
package rv64_alu_pkg;

    typedef enum logic [2:0] {
        ALU_ADD  = 3'd0,
        ALU_ADDW = 3'd1,
        ALU_SUB  = 3'd2,
        ALU_SUBW = 3'd3,
        ALU_SLL  = 3'd4,
        ALU_SLLW = 3'd5,
        ALU_SRA  = 3'd6,
        ALU_SRAW = 3'd7
    } alu_op_e;

    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;

    // Sign-extend a 32-bit W-form result to the full 64-bit register width.
    function automatic logic [63:0] sext32(input logic [31:0] v);
        return {{32{v[31]}}, v};
    endfunction

endpackage

// File: rtl/rv64_alu_arbiter_if.sv
// Request/response bundle between two ALU clients, the arbiter and the result consumer.
// No logic; latency is set by the arbiter.
// valid/ready on both request ports and on the response port.
interface rv64_alu_arbiter_if #(
    parameter int CNT_W = 16
) ();

    logic              req0_valid;
    logic [2:0]        req0_op;
    logic [63:0]       req0_a;
    logic [63:0]       req0_b;
    logic              req0_ready;

    logic              req1_valid;
    logic [2:0]        req1_op;
    logic [63:0]       req1_a;
    logic [63:0]       req1_b;
    logic              req1_ready;

    logic              resp_valid;
    logic              resp_id;
    logic [63:0]       resp_data;
    logic              resp_ready;

    logic [CNT_W-1:0]  grant_cnt0;
    logic [CNT_W-1:0]  grant_cnt1;

    // Clients and consumer side.
    modport master (
        output req0_valid, req0_op, req0_a, req0_b,
        input  req0_ready,
        output req1_valid, req1_op, req1_a, req1_b,
        input  req1_ready,
        input  resp_valid, resp_id, resp_data,
        output resp_ready,
        input  grant_cnt0, grant_cnt1
    );

    // Arbiter side.
    modport slave (
        input  req0_valid, req0_op, req0_a, req0_b,
        output req0_ready,
        input  req1_valid, req1_op, req1_a, req1_b,
        output req1_ready,
        output resp_valid, resp_id, resp_data,
        input  resp_ready,
        output grant_cnt0, grant_cnt1
    );

endinterface

// File: rtl/rv64_alu.sv
// Combinational RV64 ALU: add/sub/sll/sra in 64-bit and 32-bit (W) forms.
// Zero cycles, purely combinational.
// None; the caller decides when the result is captured.
module rv64_alu
    import rv64_alu_pkg::*;
(
    input  logic [63:0] i_a,
    input  logic [63:0] i_b,
    input  logic [2:0]  i_op,
    output logic [63:0] o_c
);

    logic [63:0] w_sum;
    logic [63:0] w_dif;
    logic [31:0] w_sllw;
    logic [31:0] w_sraw;

    // Compute every candidate result and select by opcode.
    always_comb begin
        w_sum  = i_a + i_b;
        w_dif  = i_a - i_b;
        w_sllw = i_a[31:0] << i_b[4:0];
        w_sraw = 32'($signed(i_a[31:0]) >>> i_b[4:0]);
        o_c    = '0;
        case (i_op)
            ALU_ADD:  o_c = w_sum;
            ALU_ADDW: o_c = sext32(w_sum[31:0]);
            ALU_SUB:  o_c = w_dif;
            ALU_SUBW: o_c = sext32(w_dif[31:0]);
            ALU_SLL:  o_c = i_a << i_b[5:0];
            ALU_SLLW: o_c = sext32(w_sllw);
            ALU_SRA:  o_c = 64'($signed(i_a) >>> i_b[5:0]);
            ALU_SRAW: o_c = sext32(w_sraw);
            default:  o_c = '0;
        endcase
    end

endmodule

// File: rtl/rv64_alu_arbiter.sv
// Round-robin time-sharing of one 64-bit ALU between two requesters, result held in one tagged slot.
// Accept at edge N, response visible in cycle N+1; one op per cycle with resp_ready held high.
// Readies drop to 0 while the slot is full and not being drained; resp_ready feeds readies combinationally.
module rv64_alu_arbiter
    import rv64_alu_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    rv64_alu_arbiter_if.slave bus
);

    logic              r_resp_valid;
    logic              r_resp_id;
    logic [63:0]       r_resp_data;
    logic              r_prio;
    logic [CNT_W-1:0]  r_cnt0;
    logic [CNT_W-1:0]  r_cnt1;

    logic              w_slot_free;
    logic              w_grant;
    logic              w_ready0;
    logic              w_ready1;
    logic              w_accept;
    logic [2:0]        w_op;
    logic [63:0]       w_a;
    logic [63:0]       w_b;
    logic [63:0]       w_alu_c;

    // Pick the winner and steer its operands into the shared ALU.
    always_comb begin
        w_slot_free = !r_resp_valid || bus.resp_ready;
        if (bus.req0_valid && bus.req1_valid) begin
            w_grant = r_prio;
        end else begin
            w_grant = bus.req1_valid ? REQ1 : REQ0;
        end
        // Readies are gated by reset so nothing is handed over during reset.
        w_ready0 = rst_n && w_slot_free && bus.req0_valid && (w_grant == REQ0);
        w_ready1 = rst_n && w_slot_free && bus.req1_valid && (w_grant == REQ1);
        w_accept = w_ready0 || w_ready1;
        w_op     = (w_grant == REQ1) ? bus.req1_op : bus.req0_op;
        w_a      = (w_grant == REQ1) ? bus.req1_a  : bus.req0_a;
        w_b      = (w_grant == REQ1) ? bus.req1_b  : bus.req0_b;
    end

    rv64_alu u_alu (
        .i_a  (w_a),
        .i_b  (w_b),
        .i_op (w_op),
        .o_c  (w_alu_c)
    );

    // Response slot, priority pointer and saturating grant counters.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_resp_valid <= 1'b0;
            r_resp_id    <= REQ0;
            r_resp_data  <= '0;
            r_prio       <= REQ0;
            r_cnt0       <= '0;
            r_cnt1       <= '0;
        end else if (w_accept) begin
            // A new result overwrites a slot being drained this same cycle.
            r_resp_valid <= 1'b1;
            r_resp_id    <= w_grant;
            r_resp_data  <= w_alu_c;
            r_prio       <= ~w_grant;
            if (w_grant == REQ0) begin
                if (r_cnt0 != '1) r_cnt0 <= CNT_W'(r_cnt0 + 1'b1);
            end else begin
                if (r_cnt1 != '1) r_cnt1 <= CNT_W'(r_cnt1 + 1'b1);
            end
        end else if (r_resp_valid && bus.resp_ready) begin
            r_resp_valid <= 1'b0;
        end
    end

    assign bus.req0_ready = w_ready0;
    assign bus.req1_ready = w_ready1;
    assign bus.resp_valid = r_resp_valid;
    assign bus.resp_id    = r_resp_id;
    assign bus.resp_data  = r_resp_data;
    assign bus.grant_cnt0 = r_cnt0;
    assign bus.grant_cnt1 = r_cnt1;

endmodule

// File: doc/rv64_alu_arbiter.md
# rv64_alu_arbiter

Two-requester arbiter that time-shares a single 64-bit ALU between two clients, such as the integer pipe and the address/branch unit. It accepts at most one operation per cycle through valid/ready request ports, chosen by round-robin. The ALU result is registered into a single response slot tagged with the requester id, and the slot is held until the consumer accepts it. It also keeps per-requester saturating grant counters for performance monitoring.

## Interface
Parameters:
- CNT_W, 16, width of each grant counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- req0_valid  in  1  requester 0 has an operation.
- req0_op  in  3  ALU opcode (ALU_ADD..ALU_SRAW).
- req0_a, req0_b  in  64  operands.
- req0_ready  out  1  requester 0 is accepted this cycle.
- req1_valid, req1_op, req1_a, req1_b, req1_ready  same as requester 0, for requester 1.
- resp_valid  out  1  response slot holds a result.
- resp_id  out  1  requester that produced the result.
- resp_data  out  64  ALU result.
- resp_ready  in  1  consumer takes the response this cycle.
- grant_cnt0, grant_cnt1  out  CNT_W  number of accepted requests per requester; saturates at all-ones.

## Operation
- Accept rule: accept when `slot_free = !resp_valid | resp_ready`.
  - At most one request is accepted per cycle.
  - req_ready is combinational from the valids, the priority pointer and slot_free.
- Arbitration: round-robin with a 1-bit priority pointer `prio`.
  - Only req0 valid: grant 0.
  - Only req1 valid: grant 1.
  - Both valid: grant the requester `prio` points at.
  - On every accept, `prio` becomes the other requester.
  - Reset value of `prio` is 0.
- Ready generation:
  - `reqN_ready = slot_free & grant==N & reqN_valid`.
  - A ready is never asserted toward a requester that is not valid.
  - A valid requester that is not granted sees ready=0 and must hold its valid and payload stable.
- Datapath: the granted requester's op/a/b are muxed into one ALU instance. The ALU is purely combinational; its result is captured in the response slot on accept.
- Result width rules come from the ALU and are not altered by the arbiter:
  - ADD/SUB wrap modulo 2^64.
  - ADDW/SUBW produce the 32-bit result sign-extended to 64.
- Response slot updates, in priority order:
  - On accept: resp_valid←1, resp_id←grant, resp_data←ALU out.
  - Else on `resp_valid & resp_ready`: resp_valid←0; resp_data/resp_id keep their last value.
  - Simultaneous drain and accept in the same cycle: the new result replaces the old one. This sustains one op per cycle.
- Counters: on accept, grant_cntN of the granted requester increments. At 2^CNT_W−1 it holds (saturates, no wrap).
- Reset (rst_n=0 sampled at an edge):
  - resp_valid=0, resp_id=0, resp_data=0, prio=0, both counters=0.
  - Reset mid-operation discards any undelivered result.
  - Readies are 0 while rst_n=0.

## Timing
- Latency: accept at edge N → resp_valid=1 with data after edge N (visible in cycle N+1).
- Throughput: 1 op/cycle when resp_ready is held high.
- Backpressure: while resp_valid=1 and resp_ready=0, both readies are 0 and resp_valid/resp_id/resp_data are stable.
- Combinational path exists from resp_ready to req*_ready (documented; consumers must not close a loop through it).
- No combinational path from req* inputs to resp_* outputs.

## Structure
- Shared package `rv64_alu_pkg`:
  - 3-bit opcode constants ALU_ADD=0, ALU_ADDW=1, ALU_SUB=2, ALU_SUBW=3, ALU_SLL=4, ALU_SLLW=5, ALU_SRA=6, ALU_SRAW=7.
  - Requester-id constants REQ0=0, REQ1=1.
- One sub-module: `rv64_alu`, the team's existing combinational 64-bit ALU (a, b, op → c), instantiated once.
- Arbitration, response slot and counters stay in this module.

## Test plan
- Single op: after reset, req0 ADD a=5, b=7 with resp_ready=1 → req0_ready=1 that cycle; next cycle resp_valid=1, resp_id=0, resp_data=12; grant_cnt0=1.
- Contention:
  - Stimulus: both valid from the first cycle after reset, req0 SUB 10−3 and req1 ADDW a=0x7FFF_FFFF, b=1.
  - Response: req0 granted first → 7, id 0.
  - Response: req1 granted next cycle → 0xFFFF_FFFF_8000_0000, id 1.
  - Response: back-to-back resp_valid, and prio alternates.
- Backpressure: hold resp_ready=0 for 3 cycles with both valid → both readies 0; resp_data/resp_id unchanged for those 3 cycles. Raise resp_ready → a new accept occurs the same cycle.
- Wrap: req1 SUBW a=0, b=1 → resp_data=0xFFFF_FFFF_FFFF_FFFF; req0 ADD a=0xFFFF_FFFF_FFFF_FFFF, b=1 → 0.
- Reset mid-operation: rst_n=0 while resp_valid=1 and resp_ready=0 → after that edge resp_valid=0, counters=0, prio=0; first request after release goes to req0.
- Saturation: CNT_W=2, 5 accepts from req0 → grant_cnt0 sequence 1, 2, 3, 3, 3; grant_cnt1 stays 0.
